// File: rtl/bus_line_filt.sv
// Synchronises an asynchronous status bus and glitch-filters each bit, producing
// the filtered bus, per-bit edge strobes, an any-change strobe and a saturating event counter.
module bus_line_filt #(
   parameter int                 WIDTH       = 8,
   parameter int                 SYNC_STAGES = 2,
   parameter int                 FILT_LEN    = 4,
   parameter logic [WIDTH-1:0]   RST_VAL     = '0,
   parameter int                 CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             en,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             chg,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILT_LEN - 1);

   logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] upd;
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] rise_reg;
   logic [WIDTH-1:0] fall_reg;
   logic [CNT_W-1:0] chg_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_reg[k] <= RST_VAL;
         end
      end else begin
         sync_reg[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_reg[k] <= sync_reg[k-1];
         end
      end
   end

   assign s = sync_reg[SYNC_STAGES-1];

   // Each bit owns a persistence counter; upd fires on the enabled cycle that
   // completes FILT_LEN consecutive samples disagreeing with out.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [FCW-1:0] fcnt_reg;
      logic           differ;

      assign differ  = s[gi] != out_reg[gi];
      assign upd[gi] = en && differ && (fcnt_reg == FCNT_MAX);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            fcnt_reg <= '0;
         end else if (en) begin
            if (!differ || fcnt_reg == FCNT_MAX) begin
               fcnt_reg <= '0;
            end else begin
               fcnt_reg <= fcnt_reg + FCW'(1);
            end
         end
      end
   end

   // A bit only updates when s differs from out, so flipping is taking s.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg  <= RST_VAL;
         rise_reg <= '0;
         fall_reg <= '0;
      end else begin
         out_reg  <= out_reg ^ upd;
         rise_reg <= upd & s;
         fall_reg <= upd & ~s;
      end
   end

   assign chg = |(rise_reg | fall_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_cnt_reg <= '0;
      end else if (cnt_clr) begin
         chg_cnt_reg <= '0;
      end else if (chg && chg_cnt_reg != {CNT_W{1'b1}}) begin
         chg_cnt_reg <= chg_cnt_reg + CNT_W'(1);
      end
   end

   assign out     = out_reg;
   assign rise    = rise_reg;
   assign fall    = fall_reg;
   assign chg_cnt = chg_cnt_reg;

endmodule

// File: tb/tb_bus_line_filt.sv
// Randomised and directed bench for bus_line_filt; a sliding-window reference
// model predicts every cycle's outputs and a separate monitor checks them.
module tb_bus_line_filt;

   localparam int         W  = 8;
   localparam int         SS = 2;
   localparam int         FL = 4;
   localparam int         CW = 3;
   localparam logic [7:0] RV = 8'h00;

   typedef struct packed {
      logic [W-1:0]  out;
      logic [W-1:0]  rise;
      logic [W-1:0]  fall;
      logic          chg;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  din = 8'hFF;
   logic          en = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [W-1:0]  out;
   logic [W-1:0]  rise;
   logic [W-1:0]  fall;
   logic          chg;
   logic [CW-1:0] chg_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t         exp_q [$];
   logic [W-1:0] dly_q [$];
   logic [W-1:0] win_q [$];
   logic [W-1:0]  out_m;
   logic [W-1:0]  rise_m;
   logic [W-1:0]  fall_m;
   logic [CW-1:0] cnt_m;

   always #5 clk = ~clk;

   bus_line_filt #(
      .WIDTH(W), .SYNC_STAGES(SS), .FILT_LEN(FL), .RST_VAL(RV), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .in(din), .en(en), .cnt_clr(cnt_clr),
      .out(out), .rise(rise), .fall(fall), .chg(chg), .chg_cnt(chg_cnt)
   );

   // Model: input seen by the filter is the raw bus SS edges ago; a bit flips once
   // its last FL enabled samples all disagree with the current output.
   task automatic model_step();
      logic [W-1:0] s;
      logic [W-1:0] nr;
      logic [W-1:0] nf;
      logic         chg_prev;
      logic         all_diff;
      exp_t         e;
      if (rst) begin
         dly_q.delete();
         for (int k = 0; k < SS; k++) dly_q.push_back(RV);
         win_q.delete();
         out_m  = RV;
         rise_m = '0;
         fall_m = '0;
         cnt_m  = '0;
      end else begin
         chg_prev = |(rise_m | fall_m);
         s = dly_q.pop_front();
         dly_q.push_back(din);
         nr = '0;
         nf = '0;
         if (en) begin
            win_q.push_back(s);
            if (win_q.size() > FL) void'(win_q.pop_front());
            if (win_q.size() == FL) begin
               for (int i = 0; i < W; i++) begin
                  all_diff = 1'b1;
                  foreach (win_q[j]) if (win_q[j][i] == out_m[i]) all_diff = 1'b0;
                  if (all_diff) begin
                     if (out_m[i]) nf[i] = 1'b1;
                     else          nr[i] = 1'b1;
                  end
               end
            end
            out_m = out_m ^ (nr | nf);
         end
         rise_m = nr;
         fall_m = nf;
         if (cnt_clr)                          cnt_m = '0;
         else if (chg_prev && cnt_m != 3'd7)   cnt_m = cnt_m + 3'd1;
      end
      e.out  = out_m;
      e.rise = rise_m;
      e.fall = fall_m;
      e.chg  = |(rise_m | fall_m);
      e.cnt  = cnt_m;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic [W-1:0] d, input logic e, input logic c, input logic r);
      @(negedge clk);
      din     = d;
      en      = e;
      cnt_clr = c;
      rst     = r;
      @(posedge clk);
      model_step();
   endtask

   task automatic hold(input logic [W-1:0] d, input logic e, input int n);
      for (int k = 0; k < n; k++) cyc(d, e, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out",     32'(out),     32'(e.out));
            chk("rise",    32'(rise),    32'(e.rise));
            chk("fall",    32'(fall),    32'(e.fall));
            chk("chg",     32'(chg),     32'(e.chg));
            chk("chg_cnt", 32'(chg_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin : stim
      logic [W-1:0] v;
      // reset held with all lines high, released with the bus at the reset level
      for (int k = 0; k < 3; k++) cyc(8'hFF, 1'b1, 1'b0, 1'b1);
      hold(8'h00, 1'b1, 20);
      // single-bit rise and its latency
      hold(8'h08, 1'b1, 10);
      // 3-cycle glitch rejected, then a 4-cycle-plus level accepted
      hold(8'h09, 1'b1, 3);
      hold(8'h08, 1'b1, 6);
      hold(8'h09, 1'b1, 8);
      // multi-bit change, then the same change interrupted by en=0 mid-count
      hold(8'h00, 1'b1, 10);
      hold(8'hA5, 1'b1, 10);
      hold(8'h00, 1'b1, 10);
      hold(8'hA5, 1'b1, 4);
      hold(8'hA5, 1'b0, 10);
      hold(8'hA5, 1'b1, 8);
      // toggle bit 1 ten times so the 3-bit counter saturates
      v = 8'hA5;
      for (int t = 0; t < 10; t++) begin
         v[1] = ~v[1];
         hold(v, 1'b1, 7);
      end
      // clear held across a change pulse: the clear wins
      v[1] = ~v[1];
      for (int k = 0; k < 10; k++) cyc(v, 1'b1, (k >= 3 && k <= 8), 1'b0);
      hold(v, 1'b1, 4);
      // reset while bit 2's count is in progress, then full latency again
      v[2] = ~v[2];
      hold(v, 1'b1, 4);
      for (int k = 0; k < 2; k++) cyc(v, 1'b1, 1'b0, 1'b1);
      hold(v, 1'b1, 12);
      // randomised traffic: mixed glitches and stable levels, en gaps, clears, resets
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 5) == 0) v = v ^ 8'($urandom);
         cyc(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 399) == 0));
      end
      hold(v, 1'b1, 3);
      repeat (3) @(posedge clk);
      #3;
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_line_filt.md
Name: bus_line_filt

Overview:
Parametrised successor to the team's registered bus splitter. It takes an asynchronous WIDTH-bit status bus from front-panel or inter-board lines and passes each bit through a multi-stage synchroniser and a per-bit glitch filter. It drives the filtered bus, per-bit rise/fall strobes, an any-change strobe and a saturating change-event counter. It sits between the board I/O and the synchronisation control logic.

Parameters:
WIDTH, 8, number of bus bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (>=1)
FILT_LEN, 4, consecutive enabled cycles a new level must persist before it is accepted (>=1; 1 = no filtering)
RST_VAL, 0 (WIDTH bits), reset level of the synchroniser chain and of out
CNT_W, 16, change-event counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in  in  WIDTH  raw asynchronous input bus
en  in  1  sample enable for the filter stage (the synchroniser always runs)
cnt_clr  in  1  synchronous clear of chg_cnt
out  out  WIDTH  filtered, synchronised bus (registered)
rise  out  WIDTH  one-cycle pulse: out[i] has just gone 0->1
fall  out  WIDTH  one-cycle pulse: out[i] has just gone 1->0
chg  out  1  OR of all rise and fall bits
chg_cnt  out  CNT_W  number of cycles with chg=1, saturating

Behaviour:
- Reset (async assert, released on clk): the sync chain loads RST_VAL, out=RST_VAL, filter counters=0, rise=0, fall=0, chg=0, chg_cnt=0. Assertion mid-operation aborts any pending filter count immediately.
- After release, if in==RST_VAL, no rise/fall pulses are generated.
- Synchroniser: per bit, a shift chain of SYNC_STAGES flops, clocked every cycle and not gated by en. s[i] is the last stage.
- Filter: one counter per bit, width clog2(FILT_LEN) with a minimum of 1 bit.
  - en=0: counters, out, hold. rise and fall are 0.
  - en=1, s[i]==out[i]: counter[i] is cleared to 0.
  - en=1, s[i]!=out[i], counter[i]<FILT_LEN-1: counter[i] increments.
  - en=1, s[i]!=out[i], counter[i]==FILT_LEN-1: out[i] takes s[i], counter[i] is cleared, and rise[i] or fall[i] is set on the same edge.
- Glitch rejection: a level at s lasting fewer than FILT_LEN enabled cycles never reaches out, and the counter returns to 0.
- Latency with en held high: a new stable level sampled on edge 1 appears on out at edge SYNC_STAGES+FILT_LEN. With defaults this is edge 6.
- If en drops mid-count, the count is frozen and resumes when en returns. Total enabled cycles required is still FILT_LEN.
- rise and fall are registered and high for exactly one cycle, aligned with the cycle in which out shows the new value. rise[i] and fall[i] are never both 1.
- chg is combinational OR over rise|fall. Several bits flipping in the same cycle produce a single chg pulse.
- chg_cnt is updated on the edge after a chg=1 cycle, +1 per chg cycle, and saturates at 2^CNT_W-1 without wrapping.
  - cnt_clr=1 forces chg_cnt to 0 on the next edge. If cnt_clr and chg are both 1 in the same cycle, the clear wins and that event is not counted.
- Bits are fully independent apart from the shared chg and chg_cnt.

Test Plan:
1. Reset check: hold rst=1, in=8'hFF. Then release with in=8'h00 (RST_VAL=0) -> out=00, rise, fall, chg and chg_cnt all 0 for 20 cycles, with no pulses.
2. Latency and rise pulse: en=1, set in[3]=1 once and hold it -> out[3]=1 at edge 6; rise=8'h08 for one cycle; chg one pulse; chg_cnt=1.
3. Glitch rejection: pulse in[0] high for 3 cycles with FILT_LEN=4 -> out stays 00, no pulses. Then hold it for 4 cycles -> out[0]=1 with a rise pulse.
4. Multi-bit change and en gating: in goes 00->A5 -> out=A5, rise=A5 in one cycle, single chg, chg_cnt +1. Repeat 00->A5 with en=0 for 10 cycles in mid-count -> out changes only after the remaining enabled cycles; total enabled cycles equals FILT_LEN.
5. Counter saturation and clear: CNT_W=3, toggle in[1] 10 times -> chg_cnt saturates at 7. Then assert cnt_clr in the same cycle as a chg pulse -> chg_cnt=0.
6. Reset mid-filter: assert rst while counter[2]=2 -> out returns to RST_VAL at once. After release with in unchanged, the full SYNC_STAGES+FILT_LEN latency applies again.
